// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
// Imported by the bus synchronizer and the target top level.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic [6:0] DEF_TARGET_ADDR = 7'h2A;
  localparam int         MIN_SCL_PHASE   = 4;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge and START/STOP detection.
// Flops reset high so an idle bus never looks like an edge.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_sda
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;
  logic       w_scl;
  logic       w_sda;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];

  assign o_scl_rise  = w_scl & ~r_scl_d;
  assign o_scl_fall  = ~w_scl & r_scl_d;
  assign o_start_det = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop_det  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign o_sda       = w_sda;

endmodule

// File: rtl/i2c_target_regs.sv
// Oversampled I2C target exposing a byte-addressed register port.
// First written byte loads the pointer; later bytes write with auto-increment.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEF_TARGET_ADDR,
  parameter int         PTR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  input  logic [7:0]       reg_rdata,
  output logic             reg_wr_en,
  output logic [7:0]       reg_wdata,
  output logic             busy
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_stop;
  logic w_sda;

  i2c_bus_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .i_scl       (scl_in),
    .i_sda       (sda_in),
    .o_scl_rise  (w_rise),
    .o_scl_fall  (w_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop),
    .o_sda       (w_sda)
  );

  i2c_state_t       r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic             r_full, w_full_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_rw, w_rw_nxt;
  logic             r_first, w_first_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_inc, w_inc_nxt;
  logic             r_oe, w_oe_nxt;
  logic             r_wr_en, w_wr_en_nxt;
  logic [7:0]       r_wdata, w_wdata_nxt;
  logic             r_busy, w_busy_nxt;
  logic [7:0]       w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd7;
      r_full  <= 1'b0;
      r_shift <= 8'h00;
      r_rw    <= 1'b0;
      r_first <= 1'b0;
      r_ptr   <= '0;
      r_inc   <= 1'b0;
      r_oe    <= 1'b0;
      r_wr_en <= 1'b0;
      r_wdata <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_full_nxt;
      r_shift <= w_shift_nxt;
      r_rw    <= w_rw_nxt;
      r_first <= w_first_nxt;
      r_ptr   <= w_ptr_nxt;
      r_inc   <= w_inc_nxt;
      r_oe    <= w_oe_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_full_nxt  = r_full;
    w_shift_nxt = r_shift;
    w_rw_nxt    = r_rw;
    w_first_nxt = r_first;
    w_ptr_nxt   = r_inc ? r_ptr + PTR_ONE : r_ptr;
    w_inc_nxt   = 1'b0;
    w_oe_nxt    = r_oe;
    w_wr_en_nxt = 1'b0;
    w_wdata_nxt = r_wdata;
    w_busy_nxt  = r_busy;

    if (w_start) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = 3'd7;
      w_full_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b1;
    end else if (w_stop) begin
      w_state_nxt = IDLE;
      w_full_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: ;
        ADDR: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            if (r_cnt == 3'd0) w_full_nxt = 1'b1;
            else               w_cnt_nxt  = r_cnt - 3'd1;
          end else if (w_fall && r_full) begin
            w_full_nxt = 1'b0;
            if (r_shift[7:1] == TARGET_ADDR) begin
              w_oe_nxt    = 1'b1;
              w_rw_nxt    = r_shift[0];
              w_state_nxt = ADDR_ACK;
            end else begin
              w_state_nxt = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (w_fall) begin
            w_cnt_nxt  = 3'd7;
            w_full_nxt = 1'b0;
            if (r_rw) begin
              w_shift_nxt = reg_rdata;
              w_oe_nxt    = ~reg_rdata[7];
              w_state_nxt = RD_BYTE;
            end else begin
              w_oe_nxt    = 1'b0;
              w_first_nxt = 1'b1;
              w_state_nxt = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            if (r_cnt == 3'd0) begin
              w_full_nxt = 1'b1;
              if (r_first) begin
                w_ptr_nxt   = w_byte[PTR_W-1:0];
                w_first_nxt = 1'b0;
              end else begin
                w_wr_en_nxt = 1'b1;
                w_wdata_nxt = w_byte;
                w_inc_nxt   = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt - 3'd1;
            end
          end else if (w_fall && r_full) begin
            w_full_nxt  = 1'b0;
            w_oe_nxt    = 1'b1;
            w_state_nxt = WR_ACK;
          end
        end
        WR_ACK: begin
          if (w_fall) begin
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = 3'd7;
            w_state_nxt = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (w_fall) begin
            if (r_cnt == 3'd0) begin
              w_oe_nxt    = 1'b0;
              w_full_nxt  = 1'b0;
              w_ptr_nxt   = r_ptr + PTR_ONE;
              w_state_nxt = RD_ACK;
            end else begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_oe_nxt    = ~r_shift[6];
              w_cnt_nxt   = r_cnt - 3'd1;
            end
          end
        end
        RD_ACK: begin
          // A NACK ends the read at once; an ACK waits for the fall to reload.
          if (w_rise) begin
            if (w_sda) w_state_nxt = WAIT_STOP;
            else       w_full_nxt  = 1'b1;
          end else if (w_fall && r_full) begin
            w_full_nxt  = 1'b0;
            w_shift_nxt = reg_rdata;
            w_oe_nxt    = ~reg_rdata[7];
            w_cnt_nxt   = 3'd7;
            w_state_nxt = RD_BYTE;
          end
        end
        WAIT_STOP: w_oe_nxt = 1'b0;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  assign sda_oe    = r_oe;
  assign reg_addr  = r_ptr;
  assign reg_wr_en = r_wr_en;
  assign reg_wdata = r_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-master bench for i2c_target_regs with a write-strobe scoreboard.
// Register reads come from a small local memory indexed by reg_addr.
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       rst;
  logic       r_scl;
  logic       r_sda_m;
  logic       w_sda_bus;
  logic       sda_oe;
  logic [3:0] reg_addr;
  logic [7:0] reg_rdata;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       busy;

  logic [7:0]  mem [16];
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  int n_chk  = 0;
  int n_fail = 0;
  int t_hi   = 5;
  int t_lo   = 5;
  int oe_cnt = 0;

  always #5 clk = ~clk;

  assign w_sda_bus = r_sda_m & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  i2c_target_regs #(
    .TARGET_ADDR (7'h2A),
    .PTR_W       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (r_scl),
    .sda_in    (w_sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_wr_en (reg_wr_en),
    .reg_wdata (reg_wdata),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (reg_wr_en) begin
      if (exp_wr.size() == 0)
        chk("wr_unexpected", 32'(reg_wr_en), 32'd0);
      else
        chk("wr_strobe", 32'({reg_addr, reg_wdata}),
            32'(exp_wr.pop_front()));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    r_sda_m = b;
    wclk(t_lo - 1);
    r_scl = 1'b1;
    wclk(t_hi);
    r = w_sda_bus;
    r_scl = 1'b0;
    wclk(1);
  endtask

  task automatic i2c_start();
    r_sda_m = 1'b1;
    wclk(t_lo);
    r_scl = 1'b1;
    wclk(t_hi);
    r_sda_m = 1'b0;
    wclk(t_hi);
    r_scl = 1'b0;
    wclk(1);
  endtask

  task automatic i2c_stop();
    r_sda_m = 1'b0;
    wclk(t_lo);
    r_scl = 1'b1;
    wclk(t_hi);
    r_sda_m = 1'b1;
    wclk(t_hi + 2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, d[i]);
    clk_bit(mack, r);
  endtask

  task automatic wr_byte(input string tag, input logic [7:0] b);
    logic ack;
    send_byte(b, ack);
    chk(tag, 32'(ack), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    logic [7:0] rnd;
    int         oe0;

    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);
    mem[15] = 8'hCC;
    mem[0]  = 8'h11;
    rst = 1'b1;
    r_scl = 1'b1;
    r_sda_m = 1'b1;
    wclk(4);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wclk(4);

    // pointer + two data bytes
    i2c_start();
    chk("wr_busy_start", 32'(busy), 32'd1);
    wr_byte("wr_ack_addr", 8'h54);
    wr_byte("wr_ack_ptr", 8'h03);
    exp_wr.push_back({4'd3, 8'hA5});
    wr_byte("wr_ack_d0", 8'hA5);
    exp_wr.push_back({4'd4, 8'h5A});
    wr_byte("wr_ack_d1", 8'h5A);
    chk("wr_busy_mid", 32'(busy), 32'd1);
    i2c_stop();
    chk("wr_busy_stop", 32'(busy), 32'd0);
    chk("wr_ptr_kept", 32'(reg_addr), 32'd5);
    chk("wr_queue", 32'(exp_wr.size()), 32'd0);

    // pointer then repeated-START read with wrap
    i2c_start();
    wr_byte("rd_ack_waddr", 8'h54);
    wr_byte("rd_ack_ptr", 8'h0F);
    i2c_start();
    wr_byte("rd_ack_raddr", 8'h55);
    exp_rd.push_back(mem[15]);
    exp_rd.push_back(mem[0]);
    recv_byte(1'b0, d);
    chk("rd_byte0", 32'(d), 32'(exp_rd.pop_front()));
    recv_byte(1'b1, d);
    chk("rd_byte1_wrap", 32'(d), 32'(exp_rd.pop_front()));
    wclk(4);
    chk("rd_waitstop_busy", 32'(busy), 32'd1);
    chk("rd_waitstop_oe", 32'(sda_oe), 32'd0);
    chk("rd_ptr", 32'(reg_addr), 32'd1);
    i2c_stop();
    chk("rd_busy_stop", 32'(busy), 32'd0);

    // address mismatch
    oe0 = oe_cnt;
    i2c_start();
    send_byte(8'h56, ack);
    chk("nm_ack_released", 32'(ack), 32'd1);
    chk("nm_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    chk("nm_busy", 32'(busy), 32'd1);
    i2c_stop();
    chk("nm_busy_stop", 32'(busy), 32'd0);

    // STOP in the middle of a data byte
    i2c_start();
    wr_byte("mid_ack_addr", 8'h54);
    wr_byte("mid_ack_ptr", 8'h07);
    clk_bit(1'b1, r);
    clk_bit(1'b0, r);
    clk_bit(1'b1, r);
    clk_bit(1'b1, r);
    i2c_stop();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_oe", 32'(sda_oe), 32'd0);
    chk("mid_ptr", 32'(reg_addr), 32'd7);

    // async reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h54;
      clk_bit(d[i], r);
    end
    wclk(3);
    chk("ar_ack_driven", 32'(sda_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_oe", 32'(sda_oe), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_wr_en", 32'(reg_wr_en), 32'd0);
    chk("ar_addr", 32'(reg_addr), 32'd0);
    wclk(3);
    rst = 1'b0;
    wclk(3);
    chk("ar_oe_released", 32'(sda_oe), 32'd0);
    i2c_stop();
    i2c_start();
    wr_byte("ar_ack_addr", 8'h54);
    wr_byte("ar_ack_ptr", 8'h02);
    exp_wr.push_back({4'd2, 8'h3C});
    wr_byte("ar_ack_d0", 8'h3C);
    i2c_stop();
    chk("ar_ptr", 32'(reg_addr), 32'd3);
    chk("ar_queue", 32'(exp_wr.size()), 32'd0);

    // minimum SCL phases
    t_hi = 4;
    t_lo = 4;
    rnd = 8'($urandom_range(0, 255));
    i2c_start();
    wr_byte("mt_ack_addr", 8'h54);
    wr_byte("mt_ack_ptr", 8'h08);
    exp_wr.push_back({4'd8, 8'h00});
    wr_byte("mt_ack_00", 8'h00);
    exp_wr.push_back({4'd9, 8'hFF});
    wr_byte("mt_ack_ff", 8'hFF);
    exp_wr.push_back({4'd10, 8'h81});
    wr_byte("mt_ack_81", 8'h81);
    exp_wr.push_back({4'd11, rnd});
    wr_byte("mt_ack_rnd", rnd);
    i2c_stop();
    chk("mt_busy", 32'(busy), 32'd0);
    chk("mt_ptr", 32'(reg_addr), 32'd12);
    chk("mt_queue", 32'(exp_wr.size()), 32'd0);

    wclk(5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
